// File: rtl/mult_arb_pkg.sv
// Shared types and default sizing for the multiplier arbiter and its iterative core.
package mult_arb_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_core_iterative.sv
// Shift-add unsigned multiplier: one valid_in pulse starts it, valid_out pulses once with r.
// Finishes early once the remaining multiplier bits or the shifted multiplicand are zero.
module mult_core_iterative
    import mult_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               valid_in,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               valid_out,
    output logic [2*WIDTH-1:0] r
);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic               running;

    // A fresh valid_in always reloads the datapath, so stale work never leaks out.
    always_ff @(posedge clk) begin
        valid_out <= 1'b0;
        if (valid_in) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            acc     <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (mplier == '0 || mcand == '0) begin
                valid_out <= 1'b1;
                r         <= acc;
                running   <= 1'b0;
            end else begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates N_REQ requesters onto one shared iterative multiplier, one operation in flight.
// Define MULT_ARBITER_RR_EN for round-robin arbitration; default is fixed priority, lowest index first.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned N_REQ = DEF_N_REQ
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       resp_valid,
    input  logic [N_REQ-1:0]       resp_ready,
    output logic [2*WIDTH-1:0]     resp_r,
    output logic                   busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   gidx;
    logic               found;
    logic [N_REQ-1:0]   grant;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               core_start;
    logic               core_done;
    logic [2*WIDTH-1:0] core_r;
`ifdef MULT_ARBITER_RR_EN
    logic [IDX_W-1:0]   ptr;
`endif

    // Arbiter: first valid requester, scanning from ptr (round-robin) or from 0 (fixed).
    always_comb begin
        int unsigned j;
        j     = 0;
        found = 1'b0;
        gidx  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
`ifdef MULT_ARBITER_RR_EN
            j = 32'(ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
`else
            j = i;
`endif
            if (!found && req_valid[IDX_W'(j)]) begin
                found = 1'b1;
                gidx  = IDX_W'(j);
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gidx == IDX_W'(k)) begin
                sel_a = req_a[k*WIDTH +: WIDTH];
                sel_b = req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    // Accept strobe must coincide with req_valid in the same cycle, hence combinational.
    assign grant     = found ? (N_REQ'(1) << gidx) : '0;
    assign req_ready = (state == IDLE && !reset) ? grant : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            core_start <= 1'b0;
            resp_valid <= '0;
            resp_r     <= '0;
            busy       <= 1'b0;
`ifdef MULT_ARBITER_RR_EN
            ptr        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner      <= gidx;
                        op_a       <= sel_a;
                        op_b       <= sel_b;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= START;
`ifdef MULT_ARBITER_RR_EN
                        ptr        <= (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + IDX_W'(1);
`endif
                    end
                end
                START: begin
                    core_start <= 1'b0;
                    state      <= BUSY;
                end
                // Core outputs are only trusted here, after a START has reloaded it.
                BUSY: begin
                    if (core_done) begin
                        resp_r     <= core_r;
                        resp_valid <= N_REQ'(1) << owner;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready[owner]) begin
                        resp_valid <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mult_core_iterative #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .valid_in (core_start),
        .a        (op_a),
        .b        (op_b),
        .valid_out(core_done),
        .r        (core_r)
    );

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter; grant model follows MULT_ARBITER_RR_EN when defined.
module tb_mult_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N_REQ = 4;
    localparam int LAT_MIN = 4;
    localparam int LAT_MAX = WIDTH + 4;

    typedef struct {
        int          owner;
        logic [63:0] prod;
        int          t_acc;
        bit          zero_op;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*32-1:0] req_a;
    logic [N_REQ*32-1:0] req_b;
    logic [N_REQ-1:0]   resp_valid;
    logic [N_REQ-1:0]   resp_ready;
    logic [63:0]        resp_r;
    logic               busy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cycle = 0;
    int   rr_ptr = 0;
    bit   auto_ack = 1'b0;
    bit   in_done = 1'b0;
    logic [63:0] held_r;
    logic [3:0]  held_v;
    exp_t exp_q[$];
    int   grant_log[$];

    mult_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_r(resp_r), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic int model_pick(input logic [3:0] v, input int ptr);
        int j;
        for (int i = 0; i < int'(N_REQ); i++) begin
            j = (ptr + i) % int'(N_REQ);
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2, 3:    return $urandom >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: grant model, scoreboard push on accept, pop and compare on response.
    always @(negedge clk) begin
        logic [3:0] hs;
        logic [3:0] exp_rdy;
        int pick;
        int k;
        int lat;
        exp_t e;
        cycle++;
        if (reset) begin
            exp_q.delete();
            rr_ptr  = 0;
            in_done = 1'b0;
        end else begin
            pick    = model_pick(req_valid, rr_ptr);
            exp_rdy = (busy || pick < 0) ? 4'b0 : (4'b1 << pick);
            if (req_valid != 0 || req_ready != 0)
                check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
            hs = req_ready & req_valid;
            if (hs != 0) begin
                k = 0;
                for (int i = 0; i < int'(N_REQ); i++) if (hs[i]) k = i;
                grant_log.push_back(k);
                e.owner   = k;
                e.prod    = 64'(req_a[k*32 +: 32]) * 64'(req_b[k*32 +: 32]);
                e.t_acc   = cycle;
                e.zero_op = (req_a[k*32 +: 32] == 0) || (req_b[k*32 +: 32] == 0);
                exp_q.push_back(e);
`ifdef MULT_ARBITER_RR_EN
                rr_ptr = (pick + 1) % int'(N_REQ);
`endif
            end
            if (resp_valid != 0) begin
                if (!in_done) begin
                    in_done = 1'b1;
                    held_r  = resp_r;
                    held_v  = resp_valid;
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_resp", 64'(resp_valid), 64'(0));
                    end else begin
                        e   = exp_q.pop_front();
                        lat = cycle - e.t_acc;
                        check_eq("resp_owner", 64'(resp_valid), 64'(4'b1 << e.owner));
                        check_eq("resp_r", resp_r, e.prod);
                        check_eq("lat_max", 64'(lat <= LAT_MAX), 64'(1));
                        check_eq("lat_min", 64'(lat >= LAT_MIN), 64'(1));
                        if (e.zero_op) check_eq("lat_zero", 64'(lat), 64'(LAT_MIN));
                    end
                end else begin
                    check_eq("hold_r", resp_r, held_r);
                    check_eq("hold_v", 64'(resp_valid), 64'(held_v));
                end
                check_eq("busy_done", 64'(busy), 64'(1));
            end else begin
                in_done = 1'b0;
                if (exp_q.size() != 0 && cycle - exp_q[0].t_acc > LAT_MAX) begin
                    check_eq("resp_timeout", 64'(0), 64'(1));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Auto responder: random delay, owner bit plus random noise on non-owner bits.
    initial begin
        resp_ready = '0;
        forever begin
            @(negedge clk);
            if (auto_ack && !reset && resp_valid != 0) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                @(posedge clk); #1;
                resp_ready = resp_valid | (4'($urandom) & ~resp_valid);
                @(posedge clk); #1;
                resp_ready = '0;
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send(input int k, input logic [31:0] a, input logic [31:0] b, input bit drop);
        int t;
        t = 0;
        req_a[k*32 +: 32] = a;
        req_b[k*32 +: 32] = b;
        req_valid[k] = 1'b1;
        @(negedge clk);
        while (!req_ready[k] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_eq("accept", 64'(req_ready[k]), 64'(1));
        @(posedge clk); #1;
        if (drop) req_valid[k] = 1'b0;
    endtask

    task automatic run_seq(input int k, input int n);
        for (int i = 0; i < n; i++) send(k, rnd_op(), rnd_op(), i == n - 1);
    endtask

    task automatic wait_resp(input int limit);
        int t;
        t = 0;
        while (resp_valid == 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        check_eq("resp_seen", 64'(resp_valid != 0), 64'(1));
    endtask

    task automatic wait_drain(input int limit);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || resp_valid != 0) && t < limit) begin
            @(negedge clk);
            t++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic ack_owner(input logic [3:0] mask);
        @(posedge clk); #1;
        resp_ready = mask;
        @(posedge clk); #1;
        resp_ready = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] held;
        int exp_order[5];
        int n_ops;
        logic [3:0] mask;

        reset     = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 64'(req_ready), 64'(0));
        check_eq("rst_resp_valid", 64'(resp_valid), 64'(0));
        check_eq("rst_resp_r", resp_r, 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Single request, manual consume after a hold.
        grant_log.delete();
        send(2, 32'd7, 32'd6, 1'b1);
        wait_resp(LAT_MAX + 4);
        check_eq("t1_valid", 64'(resp_valid), 64'(4'b0100));
        check_eq("t1_r", resp_r, 64'd42);
        repeat (3) @(negedge clk);
        check_eq("t1_held", 64'(resp_valid), 64'(4'b0100));
        ack_owner(4'b0100);
        check_eq("t1_released", 64'(resp_valid), 64'(0));
        check_eq("t1_idle", 64'(busy), 64'(0));
        check_eq("t1_one_grant", 64'(grant_log.size()), 64'(1));

        // Edge operands.
        auto_ack = 1'b1;
        send(0, 32'h0, 32'hFFFF_FFFF, 1'b1);
        send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_drain(200);

        // All four continuously valid from a fresh reset.
        apply_reset();
        grant_log.delete();
        for (int k = 0; k < int'(N_REQ); k++) begin
            automatic int kk = k;
            fork run_seq(kk, 5); join_none
        end
        wait fork;
        wait_drain(200);
`ifdef MULT_ARBITER_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 5; i++)
            check_eq("grant_order", 64'(grant_log[i]), 64'(exp_order[i]));

        // Backpressure with non-owner resp_ready noise and a waiting requester.
        auto_ack = 1'b0;
        send(1, 32'd123456789, 32'd987654321, 1'b1);
        wait_resp(LAT_MAX + 4);
        held = resp_r;
        fork send(3, 32'd11, 32'd13, 1'b1); join_none
        @(posedge clk); #1;
        resp_ready = 4'b1101;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_req_ready", 64'(req_ready), 64'(0));
        end
        check_eq("bp_r", resp_r, held);
        check_eq("bp_v", 64'(resp_valid), 64'(4'b0010));
        @(posedge clk); #1;
        resp_ready = 4'b0010;
        @(posedge clk); #1;
        resp_ready = '0;
        auto_ack = 1'b1;
        wait fork;
        wait_drain(200);

        // Reset while the core is busy: no response, next op correct.
        send(0, 32'd3, 32'hFFFF_FFFF, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        apply_reset();
        check_eq("rb_busy", 64'(busy), 64'(0));
        check_eq("rb_resp_valid", 64'(resp_valid), 64'(0));
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp_valid != 0) check_eq("rb_no_resp", 64'(resp_valid), 64'(0));
        end
        @(posedge clk); #1;
        send(0, 32'd3, 32'd5, 1'b1);
        wait_resp(LAT_MAX + 4);
        check_eq("rb_product", resp_r, 64'd15);
        wait_drain(200);

        // Random traffic in rounds of simultaneous requesters.
        n_ops = 0;
        while (n_ops < 1000) begin
            mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < int'(N_REQ); k++) begin
                if (mask[k]) begin
                    automatic int kk = k;
                    automatic logic [31:0] ra = rnd_op();
                    automatic logic [31:0] rb = rnd_op();
                    fork send(kk, ra, rb, 1'b1); join_none
                    n_ops++;
                end
            end
            wait fork;
        end
        wait_drain(400);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
